// File: rtl/conv_nm_pkg.sv
// rtl/conv_nm_pkg.sv - shared types and width helper for the N x M convolution stream engine
package conv_nm_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} conv_state_t;

  // Wide enough that M full-scale signed products never overflow.
  function automatic int acc_width(input int t, input int m);
    return 2 * t + $clog2(m);
  endfunction

endpackage

// File: rtl/conv_nm_stream_if.sv
// rtl/conv_nm_stream_if.sv - x/f input streams and y output stream of the convolution engine
interface conv_nm_stream_if #(
  parameter int T = 8,
  parameter int M = 4
);
  import conv_nm_pkg::*;

  localparam int ACC_W = acc_width(T, M);

  logic signed [T-1:0]     s_data_in_x;
  logic                    s_valid_x;
  logic                    s_ready_x;
  logic signed [T-1:0]     s_data_in_f;
  logic                    s_valid_f;
  logic                    s_ready_f;
  logic signed [ACC_W-1:0] m_data_out_y;
  logic                    m_valid_y;
  logic                    m_ready_y;

  modport slave (
    input  s_data_in_x, s_valid_x, s_data_in_f, s_valid_f, m_ready_y,
    output s_ready_x, s_ready_f, m_data_out_y, m_valid_y
  );

  modport master (
    output s_data_in_x, s_valid_x, s_data_in_f, s_valid_f, m_ready_y,
    input  s_ready_x, s_ready_f, m_data_out_y, m_valid_y
  );

endinterface

// File: rtl/conv_nm_stream_mac.sv
// rtl/conv_nm_stream_mac.sv - registered signed product feeding a clearable accumulator
module conv_mac #(
  parameter int T     = 8,
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [T-1:0]     a,
  input  logic signed [T-1:0]     b,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [2*T-1:0]   a_ext, b_ext, prod_q;
  logic signed [ACC_W-1:0] acc_q;

  assign a_ext = {{T{a[T-1]}}, a};
  assign b_ext = {{T{b[T-1]}}, b};
  // sum already includes the product in flight, so the final tap can be captured without an extra cycle
  assign sum   = acc_q + {{(ACC_W-2*T){prod_q[2*T-1]}}, prod_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= a_ext * b_ext;
      if (clr) begin
        acc_q <= '0;
      end else if (en) begin
        acc_q <= sum;
      end
    end
  end

endmodule

// File: rtl/conv_nm_stream_spram.sv
// rtl/conv_nm_stream_spram.sv - single-port memory with registered read data
module conv_spram #(
  parameter int W  = 8,
  parameter int D  = 16,
  parameter int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [D];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/conv_nm_stream.sv
// rtl/conv_nm_stream.sv - N-sample x M-tap valid-mode 1-D convolution over valid/ready streams
// Build option CONV_RELU_EN: negative results are emitted as zero.
module conv_nm_stream
  import conv_nm_pkg::*;
#(
  parameter int T = 8,
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic clk,
  input  logic reset,
  conv_nm_stream_if.slave stream
);

  localparam int ACC_W = acc_width(T, M);
  localparam int XA_W  = $clog2(N);
  localparam int FA_W  = $clog2(M);
  localparam int XC_W  = $clog2(N + 1);
  localparam int FC_W  = $clog2(M + 1);
  localparam int K_W   = $clog2(M + 2);
  localparam logic [XC_W-1:0] X_FULL = XC_W'(N);
  localparam logic [FC_W-1:0] F_FULL = FC_W'(M);
  localparam logic [K_W-1:0]  K_ACC0 = K_W'(2);
  localparam logic [K_W-1:0]  K_LAST = K_W'(M + 1);
  localparam logic [XA_W-1:0] J_LAST = XA_W'(N - M);

  conv_state_t state_q, state_d;
  logic [XC_W-1:0] x_cnt_q, x_cnt_d;
  logic [FC_W-1:0] f_cnt_q, f_cnt_d;
  logic [XA_W-1:0] j_q;
  logic [K_W-1:0]  k_q;
  logic ready_x_q, ready_x_d, ready_f_q, ready_f_d;
  logic valid_q;
  logic signed [ACC_W-1:0] y_q, y_d, mac_sum;
  logic x_fire, f_fire, mac_clr, mac_en, load_y, y_accept;
  logic [XA_W-1:0] x_addr;
  logic [FA_W-1:0] f_addr;
  logic signed [T-1:0] x_rd, f_rd;

  assign x_fire = ready_x_q && stream.s_valid_x;
  assign f_fire = ready_f_q && stream.s_valid_f;

  // One port per memory: written at the load count, read at j+k / k while computing.
  assign x_addr = (state_q == LOAD) ? x_cnt_q[XA_W-1:0] : j_q + XA_W'(k_q);
  assign f_addr = (state_q == LOAD) ? f_cnt_q[FA_W-1:0] : FA_W'(k_q);

  conv_spram #(.W(T), .D(N)) x_mem (
    .clk(clk), .we(x_fire), .addr(x_addr), .wdata(stream.s_data_in_x), .rdata(x_rd)
  );

  conv_spram #(.W(T), .D(M)) f_mem (
    .clk(clk), .we(f_fire), .addr(f_addr), .wdata(stream.s_data_in_f), .rdata(f_rd)
  );

  conv_mac #(.T(T), .ACC_W(ACC_W)) mac (
    .clk(clk), .reset(reset), .clr(mac_clr), .en(mac_en), .a(x_rd), .b(f_rd), .sum(mac_sum)
  );

`ifdef CONV_RELU_EN
  assign y_d = mac_sum[ACC_W-1] ? '0 : mac_sum;
`else
  assign y_d = mac_sum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_cnt_d  = x_cnt_q;
    f_cnt_d  = f_cnt_q;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    load_y   = 1'b0;
    y_accept = 1'b0;
    case (state_q)
      LOAD: begin
        if (x_fire) x_cnt_d = x_cnt_q + XC_W'(1);
        if (f_fire) f_cnt_d = f_cnt_q + FC_W'(1);
        if (x_cnt_q == X_FULL && f_cnt_q == F_FULL) state_d = COMPUTE;
      end
      COMPUTE: begin
        // k counts read issue; products reach the accumulator two cycles later
        mac_clr = (k_q == '0);
        mac_en  = (k_q >= K_ACC0);
        if (k_q == K_LAST) begin
          load_y  = 1'b1;
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (stream.m_ready_y) begin
          y_accept = 1'b1;
          if (j_q == J_LAST) begin
            state_d = LOAD;
            x_cnt_d = '0;
            f_cnt_d = '0;
          end else begin
            state_d = COMPUTE;
          end
        end
      end
      default: state_d = LOAD;
    endcase
    ready_x_d = (state_d == LOAD) && (x_cnt_d != X_FULL);
    ready_f_d = (state_d == LOAD) && (f_cnt_d != F_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_cnt_q   <= '0;
      f_cnt_q   <= '0;
      j_q       <= '0;
      k_q       <= '0;
      ready_x_q <= 1'b0;
      ready_f_q <= 1'b0;
      valid_q   <= 1'b0;
      y_q       <= '0;
    end else begin
      x_cnt_q   <= x_cnt_d;
      f_cnt_q   <= f_cnt_d;
      ready_x_q <= ready_x_d;
      ready_f_q <= ready_f_d;
      k_q       <= (state_q == COMPUTE && !load_y) ? k_q + K_W'(1) : '0;
      if (y_accept) begin
        j_q <= (j_q == J_LAST) ? '0 : j_q + XA_W'(1);
      end
      if (load_y) begin
        y_q     <= y_d;
        valid_q <= 1'b1;
      end else if (y_accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign stream.s_ready_x    = ready_x_q;
  assign stream.s_ready_f    = ready_f_q;
  assign stream.m_valid_y    = valid_q;
  assign stream.m_data_out_y = y_q;

endmodule

// File: tb/tb_conv_nm_stream.sv
// tb/tb_conv_nm_stream.sv - directed-vector bench for conv_nm_stream
module tb_conv_nm_stream;

  localparam int T    = 8;
  localparam int N    = 16;
  localparam int M    = 4;
  localparam int NOUT = N - M + 1;
  localparam int GAP  = M + 3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_nm_stream_if #(.T(T), .M(M)) bus ();

  conv_nm_stream #(.T(T), .N(N), .M(M)) dut (
    .clk(clk),
    .reset(reset),
    .stream(bus)
  );

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int xv[N], input int fv[M], input bit f_first, input bit gaps);
    int xi = 0, fi = 0, budget = 0;
    bit vx, vf, fx, ff, over_chk = 1'b0;
    while ((xi < N || fi < M) && budget < 500) begin
      vf = (fi < M);
      vx = (xi < N) && !(f_first && fi < M) && !(gaps && $urandom_range(0, 2) == 0);
      bus.s_valid_x = vx;
      if (vx) bus.s_data_in_x = 8'(xv[xi]);
      else    bus.s_data_in_x = 8'h5a;
      if (vf) begin
        bus.s_valid_f   = 1'b1;
        bus.s_data_in_f = 8'(fv[fi]);
      end else if (f_first) begin
        bus.s_valid_f   = 1'b1;
        bus.s_data_in_f = 8'sd99;
        if (!over_chk) begin
          chk("f_full_ready", int'(bus.s_ready_f), 0);
          over_chk = 1'b1;
        end
      end else begin
        bus.s_valid_f   = 1'b0;
        bus.s_data_in_f = '0;
      end
      fx = vx && bus.s_ready_x;
      ff = vf && bus.s_ready_f;
      tick;
      budget++;
      xi += int'(fx);
      fi += int'(ff);
    end
    bus.s_valid_x = 1'b0;
    bus.s_valid_f = 1'b0;
    chk("x_loaded", xi, N);
    chk("f_loaded", fi, M);
    chk("rdy_x_drop", int'(bus.s_ready_x), 0);
    chk("rdy_f_drop", int'(bus.s_ready_f), 0);
  endtask

  task automatic collect(input int n_out, input int ev[NOUT], input int stall_idx, input int stall_len);
    int got = 0, stall = 0, budget = 0, held = 0;
    int acc_cyc[NOUT];
    while (got < n_out && budget < 1000) begin
      if (stall > 0 && stall < stall_len) begin
        bus.m_ready_y = 1'b0;
        chk("stall_valid", int'(bus.m_valid_y), 1);
        chk("stall_data", int'($signed(bus.m_data_out_y)), held);
        stall++;
      end else if (stall == 0 && stall_len > 0 && got == stall_idx && bus.m_valid_y) begin
        bus.m_ready_y = 1'b0;
        held = int'($signed(bus.m_data_out_y));
        stall = 1;
      end else begin
        bus.m_ready_y = 1'b1;
      end
      if (bus.m_valid_y && bus.m_ready_y) begin
        chk($sformatf("y%0d", got), int'($signed(bus.m_data_out_y)), ev[got]);
        acc_cyc[got] = cyc;
        got++;
      end
      tick;
      budget++;
    end
    bus.m_ready_y = 1'b0;
    chk("n_outputs", got, n_out);
    for (int i = 1; i < got; i++) begin
      chk($sformatf("gap%0d", i), acc_cyc[i] - acc_cyc[i-1], GAP + ((i == stall_idx) ? stall_len : 0));
    end
  endtask

  task automatic chk_reload;
    chk("valid_drop", int'(bus.m_valid_y), 0);
    chk("rdy_x_back", int'(bus.s_ready_x), 1);
    chk("rdy_f_back", int'(bus.s_ready_f), 1);
  endtask

  initial begin
    int xv[N];
    int fv[M];
    int ev[NOUT];

    reset = 1'b1;
    bus.s_valid_x = 1'b0;
    bus.s_data_in_x = '0;
    bus.s_valid_f = 1'b0;
    bus.s_data_in_f = '0;
    bus.m_ready_y = 1'b0;
    repeat (3) tick;
    chk("rst_ready_x", int'(bus.s_ready_x), 0);
    chk("rst_ready_f", int'(bus.s_ready_f), 0);
    chk("rst_valid", int'(bus.m_valid_y), 0);
    chk("rst_data", int'($signed(bus.m_data_out_y)), 0);
    reset = 1'b0;
    tick;
    chk("init_rdy_x", int'(bus.s_ready_x), 1);
    chk("init_rdy_f", int'(bus.s_ready_f), 1);

    // ramp x with unit taps, interleaved load, continuous ready
    for (int i = 0; i < N; i++) xv[i] = i + 1;
    for (int i = 0; i < M; i++) fv[i] = 1;
    for (int j = 0; j < NOUT; j++) ev[j] = 10 + 4 * j;
    load(xv, fv, 1'b0, 1'b0);
    collect(NOUT, ev, -1, 0);
    chk_reload();

    // taps first, then x with random gaps; extra f valids must be refused
    load(xv, fv, 1'b1, 1'b1);
    collect(NOUT, ev, -1, 0);
    chk_reload();

    // full-scale negative inputs: 4 * 16384
    for (int i = 0; i < N; i++) xv[i] = -128;
    for (int i = 0; i < M; i++) fv[i] = -128;
    for (int j = 0; j < NOUT; j++) ev[j] = 65536;
    load(xv, fv, 1'b0, 1'b1);
    collect(NOUT, ev, -1, 0);
    chk_reload();

    // backpressure: output 3 held for 5 cycles
    for (int i = 0; i < N; i++) xv[i] = i + 1;
    for (int i = 0; i < M; i++) fv[i] = 1;
    for (int j = 0; j < NOUT; j++) ev[j] = 10 + 4 * j;
    load(xv, fv, 1'b0, 1'b0);
    collect(NOUT, ev, 3, 5);
    chk_reload();

    // negative sums
    for (int i = 0; i < M; i++) fv[i] = -1;
    for (int j = 0; j < NOUT; j++) begin
`ifdef CONV_RELU_EN
      ev[j] = 0;
`else
      ev[j] = -(10 + 4 * j);
`endif
    end
    load(xv, fv, 1'b0, 1'b0);
    collect(NOUT, ev, -1, 0);
    chk_reload();

    // reset while output 6 is being computed, then reload with doubled taps
    for (int i = 0; i < M; i++) fv[i] = 1;
    for (int j = 0; j < NOUT; j++) ev[j] = 10 + 4 * j;
    load(xv, fv, 1'b0, 1'b0);
    collect(6, ev, -1, 0);
    repeat (2) tick;
    reset = 1'b1;
    tick;
    chk("mid_rst_ready_x", int'(bus.s_ready_x), 0);
    chk("mid_rst_ready_f", int'(bus.s_ready_f), 0);
    chk("mid_rst_valid", int'(bus.m_valid_y), 0);
    chk("mid_rst_data", int'($signed(bus.m_data_out_y)), 0);
    reset = 1'b0;
    tick;
    chk("post_rst_rdy_x", int'(bus.s_ready_x), 1);
    chk("post_rst_rdy_f", int'(bus.s_ready_f), 1);
    for (int i = 0; i < M; i++) fv[i] = 2;
    for (int j = 0; j < NOUT; j++) ev[j] = 20 + 8 * j;
    load(xv, fv, 1'b0, 1'b0);
    collect(NOUT, ev, -1, 0);
    chk_reload();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
